// File: rtl/scr1_tcm_pkg.sv
// Shared types, defaults and address-decode helper for the TCM controller.
package scr1_tcm_pkg;

  localparam logic [31:0] SCR1_TCM_SIZE_DEFAULT = 32'h00010000;
  localparam logic [31:0] SCR1_TCM_BASE_DEFAULT = 32'h00480000;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE = 2'd0,
    SCR1_MEM_RESP_RDY  = 2'd1,
    SCR1_MEM_RESP_ER   = 2'd2
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'd0,
    SCR1_MEM_WIDTH_HWORD = 2'd1,
    SCR1_MEM_WIDTH_WORD  = 2'd2
  } type_scr1_mem_width_e;

  // Window hit: base must be aligned to size, size a power of two.
  function automatic logic tcm_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] size);
    return ((addr & ~(size - 32'd1)) == base);
  endfunction

endpackage

// File: rtl/scr1_tcm_rdata_align.sv
// Per-port response FSM and read-data aligner for the TCM controller.
// Build option SCR1_TCM_RDATA_HOLD_EN keeps the last RDY data visible while IDLE.
module scr1_tcm_rdata_align
  import scr1_tcm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 accept,
  input  logic                 err,
  input  logic                 wr,
  input  logic [1:0]           off,
  input  type_scr1_mem_width_e width,
  input  logic [31:0]          q,
  output type_scr1_mem_resp_e  resp,
  output logic [31:0]          rdata
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e               state_r;
  state_e               state_next_s;
  logic                 err_r;
  logic                 wr_r;
  logic [1:0]           off_r;
  type_scr1_mem_width_e width_r;
  logic [31:0]          shift_s;
  logic [31:0]          align_s;
  logic [31:0]          rdy_data_s;

  // Response state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and response code
  always_comb begin
    state_next_s = ST_IDLE;
    resp         = SCR1_MEM_RESP_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept) state_next_s = ST_RESP;
        else        state_next_s = ST_IDLE;
      end
      ST_RESP: begin
        if (accept) state_next_s = ST_RESP;
        else        state_next_s = ST_IDLE;
        if (err_r)  resp = SCR1_MEM_RESP_ER;
        else        resp = SCR1_MEM_RESP_RDY;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Request attributes captured at accept, used when RAM data returns
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r   <= 1'b0;
      wr_r    <= 1'b0;
      off_r   <= 2'b00;
      width_r <= SCR1_MEM_WIDTH_BYTE;
    end else if (accept) begin
      err_r   <= err;
      wr_r    <= wr;
      off_r   <= off;
      width_r <= width;
    end
  end

  assign shift_s = q >> {off_r, 3'b000};

  // Zero-extend the shifted word to the requested width
  always_comb begin
    align_s = 32'd0;
    case (width_r)
      SCR1_MEM_WIDTH_BYTE:  align_s = {24'd0, shift_s[7:0]};
      SCR1_MEM_WIDTH_HWORD: align_s = {16'd0, shift_s[15:0]};
      SCR1_MEM_WIDTH_WORD:  align_s = shift_s;
      default:              align_s = 32'd0;
    endcase
  end

  // A write completes with RDY but carries no data
  assign rdy_data_s = wr_r ? 32'd0 : align_s;

`ifdef SCR1_TCM_RDATA_HOLD_EN
  logic [31:0] hold_r;

  // Last RDY data, shown again while the port is idle
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= 32'd0;
    end else if (resp == SCR1_MEM_RESP_RDY) begin
      hold_r <= rdy_data_s;
    end
  end

  // Output data select, hold variant
  always_comb begin
    rdata = hold_r;
    case (resp)
      SCR1_MEM_RESP_RDY: rdata = rdy_data_s;
      SCR1_MEM_RESP_ER:  rdata = 32'd0;
      default:           rdata = hold_r;
    endcase
  end
`else
  // Output data select, zero when not RDY
  always_comb begin
    rdata = 32'd0;
    if (resp == SCR1_MEM_RESP_RDY) begin
      rdata = rdy_data_s;
    end else begin
      rdata = 32'd0;
    end
  end
`endif

endmodule

// File: rtl/scr1_tcm_ctrl.sv
// Bridges IMEM (port A, read-only) and DMEM (port B, read/write) onto a dual-port TCM RAM.
// Optional build macro: SCR1_TCM_RDATA_HOLD_EN (hold read data while idle).
module scr1_tcm_ctrl
  import scr1_tcm_pkg::*;
#(
  parameter logic [31:0] SCR1_SIZE     = SCR1_TCM_SIZE_DEFAULT,
  parameter logic [31:0] SCR1_TCM_BASE = SCR1_TCM_BASE_DEFAULT,
  localparam int         AW            = $clog2(SCR1_SIZE) - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_req,
  input  logic [31:0]          imem_addr,
  output logic                 imem_req_ack,
  output logic [31:0]          imem_rdata,
  output type_scr1_mem_resp_e  imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_cmd,
  input  type_scr1_mem_width_e dmem_width,
  input  logic [31:0]          dmem_addr,
  input  logic [31:0]          dmem_wdata,
  output logic                 dmem_req_ack,
  output logic [31:0]          dmem_rdata,
  output type_scr1_mem_resp_e  dmem_resp,
  output logic                 rena,
  output logic [AW-1:0]        addra,
  input  logic [31:0]          qa,
  output logic                 renb,
  output logic                 wenb,
  output logic [3:0]           webb,
  output logic [AW-1:0]        addrb,
  output logic [31:0]          datab,
  input  logic [31:0]          qb
);

  logic       imem_hit_s;
  logic       imem_err_s;
  logic       dmem_hit_s;
  logic       dmem_mis_s;
  logic       dmem_err_s;
  logic       dmem_ok_s;
  logic [1:0] dmem_off_s;
  logic [3:0] dmem_be_s;

  assign imem_req_ack = imem_req;
  assign dmem_req_ack = dmem_req;

  assign imem_hit_s = tcm_hit(imem_addr, SCR1_TCM_BASE, SCR1_SIZE);
  assign imem_err_s = ~imem_hit_s;
  assign rena       = imem_req & imem_hit_s;
  assign addra      = imem_addr[AW+1:2];

  assign dmem_off_s = dmem_addr[1:0];
  assign dmem_hit_s = tcm_hit(dmem_addr, SCR1_TCM_BASE, SCR1_SIZE);

  // Alignment check per access width; an unknown width is treated as an error
  always_comb begin
    dmem_mis_s = 1'b0;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:  dmem_mis_s = 1'b0;
      SCR1_MEM_WIDTH_HWORD: dmem_mis_s = dmem_off_s[0];
      SCR1_MEM_WIDTH_WORD:  dmem_mis_s = |dmem_off_s;
      default:              dmem_mis_s = 1'b1;
    endcase
  end

  assign dmem_err_s = ~dmem_hit_s | dmem_mis_s;
  assign dmem_ok_s  = dmem_req & ~dmem_err_s;
  assign renb       = dmem_ok_s & ~dmem_cmd;
  assign wenb       = dmem_ok_s & dmem_cmd;
  assign addrb      = dmem_addr[AW+1:2];
  assign datab      = dmem_wdata << {dmem_off_s, 3'b000};

  // Byte-lane enables for a legal write, otherwise none
  always_comb begin
    dmem_be_s = 4'b0000;
    if (wenb) begin
      case (dmem_width)
        SCR1_MEM_WIDTH_BYTE:  dmem_be_s = 4'b0001 << dmem_off_s;
        SCR1_MEM_WIDTH_HWORD: dmem_be_s = 4'b0011 << dmem_off_s;
        SCR1_MEM_WIDTH_WORD:  dmem_be_s = 4'b1111;
        default:              dmem_be_s = 4'b0000;
      endcase
    end else begin
      dmem_be_s = 4'b0000;
    end
  end

  assign webb = dmem_be_s;

  scr1_tcm_rdata_align i_imem_align (
    .clk    (clk),
    .rst    (rst),
    .accept (imem_req),
    .err    (imem_err_s),
    .wr     (1'b0),
    .off    (imem_addr[1:0]),
    .width  (SCR1_MEM_WIDTH_WORD),
    .q      (qa),
    .resp   (imem_resp),
    .rdata  (imem_rdata)
  );

  scr1_tcm_rdata_align i_dmem_align (
    .clk    (clk),
    .rst    (rst),
    .accept (dmem_req),
    .err    (dmem_err_s),
    .wr     (dmem_cmd),
    .off    (dmem_off_s),
    .width  (dmem_width),
    .q      (qb),
    .resp   (dmem_resp),
    .rdata  (dmem_rdata)
  );

endmodule
